// File: rtl/management_bus_bridge.sv
// management_bus_bridge
//   Turns a byte stream from an SPI slave core into register-bus reads and
//   writes. Each transaction starts with a two-byte header: bit 15 selects
//   write (1) or read (0), and bits 14:0 give the start address. In a write,
//   every later byte is written to an auto-incrementing address. In a read,
//   bytes are fetched from auto-incrementing addresses and offered to the
//   SPI core one at a time.
//
//   Optional build macro: MGMT_BRIDGE_RD_TIMEOUT_EN adds a read-wait timeout
//   of TIMEOUT_CYCLES cycles. On timeout the bridge returns 0xFF and sets the
//   sticky rd_timeout flag. Without the macro, reads wait indefinitely and
//   rd_timeout is tied to 0.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   spi_start, spi_end    chip-select assert / deassert pulses
//   rx_valid, rx_data     byte received from the SPI core
//   tx_valid, tx_data,    byte offered to the SPI core (moves on
//   tx_ready              tx_valid && tx_ready)
//   rd_en, rd_addr,       register read: one-cycle rd_en, response on
//   rd_valid, rd_data     rd_valid
//   wr_en, wr_addr,       register write strobe
//   wr_data
//   rd_timeout            sticky read-timeout flag
module management_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_start,
  input  logic        spi_end,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic        rd_valid,
  input  logic [7:0]  rd_data,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        rd_timeout
);

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, ADDR_LO, RD_ISSUE, RD_WAIT, RD_HOLD, WRITE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hdr_hi_q, hdr_hi_d;
  logic [14:0] addr_q, addr_d;
  logic [14:0] rd_addr_q, rd_addr_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        wr_en_q, wr_en_d;
  logic [14:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        drain_q, drain_d;
  // The response came back in the rd_en cycle; it is parked in tx_data and
  // presented from RD_WAIT, so a read still takes 3 cycles per byte.
  logic        early_q, early_d;
  logic        issue;
  logic        abort;
  logic        tmo_hit;

  // A read is issued only when no aborted read is still in flight.
  assign issue = (state_q == RD_ISSUE) && !drain_q;
  assign abort = spi_start || spi_end;

`ifdef MGMT_BRIDGE_RD_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_timeout_q, rd_timeout_d;
  logic          tmo_active;

  // The counter runs while the bridge waits on a live read, and also while it
  // drains a read that was aborted. In both cases the counter is timing the
  // same outstanding read.
  assign tmo_active = ((state_q == RD_WAIT) && !early_q) || drain_q;
  assign tmo_hit    = tmo_active && !rd_valid && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d        = (tmo_active && !rd_valid && !tmo_hit) ? cnt_q + 1'b1 : '0;
    rd_timeout_d = rd_timeout_q;
    if (spi_start)
      rd_timeout_d = 1'b0;
    else if (tmo_hit && !spi_end && (state_q == RD_WAIT))
      rd_timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      rd_timeout_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rd_timeout_q <= rd_timeout_d;
    end
  end

  assign rd_timeout = rd_timeout_q;
`else
  assign tmo_hit    = 1'b0;
  assign rd_timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    hdr_hi_d   = hdr_hi_q;
    addr_d     = addr_q;
    rd_addr_d  = rd_addr_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    drain_d    = drain_q;
    early_d    = early_q;

    // The late response to an aborted read is swallowed here.
    if (drain_q && (rd_valid || tmo_hit))
      drain_d = 1'b0;

    if (spi_start) begin
      tx_valid_d = 1'b0;
      early_d    = 1'b0;
      if (rx_valid) begin
        hdr_hi_d = rx_data;
        state_d  = ADDR_LO;
      end else begin
        state_d  = ADDR_HI;
      end
    end else if (spi_end) begin
      tx_valid_d = 1'b0;
      early_d    = 1'b0;
      state_d    = IDLE;
    end else begin
      case (state_q)
        ADDR_HI: begin
          if (rx_valid) begin
            hdr_hi_d = rx_data;
            state_d  = ADDR_LO;
          end
        end
        ADDR_LO: begin
          if (rx_valid) begin
            addr_d  = {hdr_hi_q[6:0], rx_data};
            state_d = hdr_hi_q[7] ? WRITE : RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (issue) begin
            if (rd_valid) begin
              tx_data_d = rd_data;
              early_d   = 1'b1;
            end
            state_d = RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (early_q || rd_valid) begin
            if (!early_q)
              tx_data_d = rd_data;
            early_d    = 1'b0;
            tx_valid_d = 1'b1;
            state_d    = RD_HOLD;
          end else if (tmo_hit) begin
            tx_data_d  = 8'hFF;
            tx_valid_d = 1'b1;
            state_d    = RD_HOLD;
          end
        end
        RD_HOLD: begin
          if (tx_ready) begin
            tx_valid_d = 1'b0;
            addr_d     = addr_q + 15'd1;
            state_d    = RD_ISSUE;
          end
        end
        WRITE: begin
          if (rx_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = rx_data;
            addr_d    = addr_q + 15'd1;
          end
        end
        default: ;
      endcase
    end

    // An abort with no response yet leaves a read in flight.
    if (abort && !rd_valid &&
        (issue || ((state_q == RD_WAIT) && !early_q && !tmo_hit)))
      drain_d = 1'b1;

    // rd_addr is loaded only when a read can actually issue. This keeps it
    // steady while an aborted read is still being drained.
    if ((state_d == RD_ISSUE) && !drain_d)
      rd_addr_d = addr_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hdr_hi_q   <= '0;
      addr_q     <= '0;
      rd_addr_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      drain_q    <= 1'b0;
      early_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_hi_q   <= hdr_hi_d;
      addr_q     <= addr_d;
      rd_addr_q  <= rd_addr_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      drain_q    <= drain_d;
      early_q    <= early_d;
    end
  end

  assign rd_en    = issue;
  assign rd_addr  = {1'b0, rd_addr_q};
  assign wr_en    = wr_en_q;
  assign wr_addr  = {1'b0, wr_addr_q};
  assign wr_data  = wr_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;

endmodule
